fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Sits directly upstream of the decode control unit.
//  Holds the PC and issues one request per cycle to a synchronous instruction memory.
//  Buffers returned words in a small FIFO so that a decode stall loses nothing.
//  Presents {valid, pc, instr, opcode} to decode. Supports PC redirect (branch/jump) with squash.
// PARAMETERS
//  ADDR_W      32  PC / imem address width
//  INSTR_W     32  instruction width; opcode = instr[INSTR_W-1 -: 4]
//  RESET_PC    0   PC value loaded on reset
//  PC_INC      4   PC increment per fetched instruction
//  FIFO_DEPTH  2   instruction buffer entries (>=2; 2 gives full throughput)
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, asynchronous, active-high
//  stall        in   1        decode cannot accept this cycle
//  redirect     in   1        load redirect_pc, flush buffer, squash in-flight fetch
//  redirect_pc  in   ADDR_W   new PC on redirect
//  imem_req     out  1        read request this cycle
//  imem_addr    out  ADDR_W   read address (= PC register)
//  imem_rdata   in   INSTR_W  read data, valid the cycle after imem_req
//  if_valid     out  1        if_instr/if_pc/if_opcode hold a valid instruction
//  if_pc        out  ADDR_W   PC of the presented instruction
//  if_instr     out  INSTR_W  presented instruction
//  if_opcode    out  4        if_instr[INSTR_W-1 -: 4], feeds decode opcode input
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, FIFO empty, inflight=0.
//    if_valid=0, if_pc=0, if_instr=0, if_opcode=0, imem_req=0 while reset is high.
//  - pop = if_valid & ~stall & ~redirect. FIFO head advances on pop.
//  - Request rule: imem_req = ~redirect & (count + inflight - pop < FIFO_DEPTH).
//    On a request edge: pc <= pc + PC_INC (mod 2^ADDR_W), inflight <= 1, req_pc <= pc.
//  - Response: the cycle after a request, imem_rdata is pushed with req_pc, unless squashed.
//    Push and pop in the same cycle are legal.
//  - Latency: request in cycle c -> if_valid in cycle c+2 (FIFO-registered output, no bypass).
//    Steady state with no stall: one instruction per cycle.
//  - Stall: if_* outputs hold their value. Requests stop once count+inflight reaches FIFO_DEPTH.
//    No instruction is dropped or duplicated.
//  - Redirect (priority over stall and pop) at edge E:
//    FIFO cleared, in-flight response discarded, pc <= redirect_pc, no request that cycle.
//    imem_req=1 with imem_addr=redirect_pc in the cycle after E.
//    if_valid for redirect_pc two cycles later.
//  - Redirect asserted on consecutive cycles: the last redirect_pc wins.
//  - PC wrap-around at 2^ADDR_W is silent.
//  - Reset mid-operation: immediate return to reset state; the in-flight response is ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    adds outputs perf_fetched[31:0] (increments on each pop)
//    and perf_stall_cyc[31:0] (increments each cycle if_valid & stall).
//    Both reset to 0 and wrap.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - Shared package fetch_pkg: INSTR_W, ADDR_W defaults, OPCODE_MSB, 4-bit opcode
//    localparams (NOP 0x0 .. BGT 0xF, shared with decode), fifo_entry_t = {pc, instr}.
//  - Sub-module fetch_fifo: sync FIFO of fifo_entry_t.
//    Ports: push, pop, clear, count, head. Clear has priority over push.
//  - Top: PC register, inflight/req_pc/squash flags, request logic, optional counters.
// TESTING
//  1. RESET_PC=0, imem[i]=0x1000_0000+i, stall=0:
//     if_valid rises 2 cycles after the first request; if_pc=0,4,8,12 on consecutive
//     cycles; if_opcode=4'h1.
//  2. Stall held 3 cycles while if_pc=8:
//     if_pc stays 8, imem_req drops once 2 entries are buffered;
//     after release if_pc=8,12,16 back-to-back.
//  3. redirect=1, redirect_pc=0x100 with a fetch in flight:
//     the next if_valid shows if_pc=0x100, then 0x104; no old-stream PC appears after redirect.
//  4. redirect and stall both high with FIFO full:
//     FIFO flushed, imem_addr=0x100 next cycle, if_valid=0 until 0x100 arrives.
//  5. RESET_PC=0xFFFF_FFF8: if_pc=0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//     Reset asserted mid-stream: if_valid=0 immediately, restart at RESET_PC.
//  6. With FETCH_PERF_CNT_EN: 10 pops plus 3 stalled-valid cycles
//     -> perf_fetched=10, perf_stall_cyc=3.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg
// Shared fetch/decode definitions: widths, opcode map and instruction buffer entry.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;
    localparam int OPCODE_MSB    = FETCH_INSTR_W - 1;

    // Opcode map shared with the decode control unit
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LUI = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_BNE = 4'hD;
    localparam logic [3:0] OP_BLT = 4'hE;
    localparam logic [3:0] OP_BGT = 4'hF;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo
// Synchronous instruction buffer; clear wins over push, head is registered storage.
// Revision: 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fifo_entry_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [CW-1:0] count,
    output T              head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    T              r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_do_pop  = pop & (r_count != '0);
        w_do_push = push & ((r_count != CW'(DEPTH)) | w_do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data-only; the top gates outputs with the occupancy count
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit
// Instruction fetch: PC, one imem request per cycle, buffered output to decode,
// redirect with squash. Optional perf counters under FETCH_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = FETCH_ADDR_W,
    parameter int                INSTR_W    = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_INC     = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall_cyc
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_req;
    logic [CW:0]       w_occ;
    logic [CW-1:0]     w_count;
    entry_t            w_head;
    entry_t            w_push_entry;

    always_comb begin
        w_valid            = (w_count != '0);
        w_pop              = w_valid & ~stall & ~redirect;
        // A response landing in a redirect cycle is dropped by the FIFO clear
        w_push             = r_inflight & ~redirect;
        w_occ              = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
        w_req              = ~reset & ~redirect & (w_occ < (CW+1)'(FIFO_DEPTH));
        w_push_entry.pc    = r_req_pc;
        w_push_entry.instr = imem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc     <= r_pc + ADDR_W'(PC_INC);
                r_req_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .clear     (redirect),
        .count     (w_count),
        .head      (w_head)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = w_valid;
    assign if_pc     = w_valid ? w_head.pc    : '0;
    assign if_instr  = w_valid ? w_head.instr : '0;
    assign if_opcode = if_instr[INSTR_W-1 -: 4];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall_cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched   <= '0;
            r_perf_stall_cyc <= '0;
        end else begin
            if (w_pop)            r_perf_fetched   <= r_perf_fetched + 32'd1;
            if (w_valid && stall) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit
// Directed bench: two fetch units (RESET_PC 0 and 0xFFFF_FFF8) against imem models.
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RESET_PC = 0
    logic        rst_a, stall_a, redir_a;
    logic [31:0] redir_pc_a;
    logic        req_a, valid_a;
    logic [31:0] addr_a, rdata_a, pc_a, instr_a;
    logic [3:0]  op_a;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_f_a, perf_s_a;
`endif

    // DUT B: RESET_PC = 0xFFFF_FFF8
    logic        rst_b, stall_b, redir_b;
    logic [31:0] redir_pc_b;
    logic        req_b, valid_b;
    logic [31:0] addr_b, rdata_b, pc_b, instr_b;
    logic [3:0]  op_b;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_f_b, perf_s_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .stall       (stall_a),
        .redirect    (redir_a),
        .redirect_pc (redir_pc_a),
        .imem_req    (req_a),
        .imem_addr   (addr_a),
        .imem_rdata  (rdata_a),
        .if_valid    (valid_a),
        .if_pc       (pc_a),
        .if_instr    (instr_a),
        .if_opcode   (op_a)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_f_a),
        .perf_stall_cyc (perf_s_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .stall       (stall_b),
        .redirect    (redir_b),
        .redirect_pc (redir_pc_b),
        .imem_req    (req_b),
        .imem_addr   (addr_b),
        .imem_rdata  (rdata_b),
        .if_valid    (valid_b),
        .if_pc       (pc_b),
        .if_instr    (instr_b),
        .if_opcode   (op_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_f_b),
        .perf_stall_cyc (perf_s_b)
`endif
    );

    // imem word i holds 0x1000_0000 + i
    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (req_a) rdata_a <= imem(addr_a);
        if (req_b) rdata_b <= imem(addr_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive DUT A inputs, then let combinational outputs settle
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall_a    = st;
        redir_a    = rd;
        redir_pc_a = rpc;
        #1;
    endtask

    initial begin
        rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; redir_pc_a = '0;
        rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; redir_pc_b = '0;
        rdata_a = '0; rdata_b = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(valid_a), 32'd0);
        chk("rst_pc",     pc_a,         32'd0);
        chk("rst_instr",  instr_a,      32'd0);
        chk("rst_opcode", 32'(op_a),    32'd0);
        chk("rst_req",    32'(req_a),   32'd0);

        // Basic stream
        rst_a = 1'b0; #1;
        chk("c0_req",   32'(req_a),   32'd1);
        chk("c0_addr",  addr_a,       32'h0);
        cyc(0, 0, 0);
        chk("c1_valid", 32'(valid_a), 32'd0);
        chk("c1_addr",  addr_a,       32'h4);
        cyc(0, 0, 0);
        chk("c2_valid", 32'(valid_a), 32'd1);
        chk("c2_pc",    pc_a,         32'h0);
        chk("c2_instr", instr_a,      32'h1000_0000);
        chk("c2_op",    32'(op_a),    32'h1);
        cyc(0, 0, 0);
        chk("c3_pc",    pc_a,         32'h4);

        // Stall three cycles at pc 8
        cyc(1, 0, 0);
        chk("s0_pc",    pc_a,         32'h8);
        chk("s0_req",   32'(req_a),   32'd0);
        cyc(1, 0, 0);
        chk("s1_pc",    pc_a,         32'h8);
        chk("s1_req",   32'(req_a),   32'd0);
        cyc(1, 0, 0);
        chk("s2_pc",    pc_a,         32'h8);
        chk("s2_valid", 32'(valid_a), 32'd1);
        cyc(0, 0, 0);
        chk("r0_pc",    pc_a,         32'h8);
        chk("r0_addr",  addr_a,       32'h10);
        cyc(0, 0, 0);
        chk("r1_pc",    pc_a,         32'hC);
        cyc(0, 0, 0);
        chk("r2_pc",    pc_a,         32'h10);

        // Redirect with a fetch in flight
        cyc(0, 1, 32'h100);
        chk("rd_req",   32'(req_a),   32'd0);
        cyc(0, 0, 0);
        chk("rd1_valid", 32'(valid_a), 32'd0);
        chk("rd1_req",  32'(req_a),   32'd1);
        chk("rd1_addr", addr_a,       32'h100);
        cyc(0, 0, 0);
        chk("rd2_valid", 32'(valid_a), 32'd0);
        cyc(0, 0, 0);
        chk("rd3_pc",   pc_a,         32'h100);
        chk("rd3_instr", instr_a,     32'h1000_0040);
        cyc(0, 0, 0);
        chk("rd4_pc",   pc_a,         32'h104);

        // Redirect and stall together with the buffer full
        cyc(1, 0, 0);
        chk("f0_pc",    pc_a,         32'h108);
        cyc(1, 0, 0);
        chk("f1_pc",    pc_a,         32'h108);
        cyc(1, 1, 32'h100);
        chk("f2_req",   32'(req_a),   32'd0);
        cyc(1, 0, 0);
        chk("f3_valid", 32'(valid_a), 32'd0);
        chk("f3_addr",  addr_a,       32'h100);
        chk("f3_req",   32'(req_a),   32'd1);
        cyc(1, 0, 0);
        chk("f4_valid", 32'(valid_a), 32'd0);
        cyc(0, 0, 0);
        chk("f5_valid", 32'(valid_a), 32'd1);
        chk("f5_pc",    pc_a,         32'h100);
        cyc(0, 0, 0);
        chk("f6_pc",    pc_a,         32'h104);

        // Back-to-back redirects: last target wins
        cyc(0, 1, 32'h200);
        cyc(0, 1, 32'h300);
        chk("bb_req",   32'(req_a),   32'd0);
        cyc(0, 0, 0);
        chk("bb_addr",  addr_a,       32'h300);
        cyc(0, 0, 0);
        chk("bb1_valid", 32'(valid_a), 32'd0);
        cyc(0, 0, 0);
        chk("bb2_pc",   pc_a,         32'h300);

        // PC wrap-around and mid-stream reset on DUT B
        rst_b = 1'b0; #1;
        chk("w0_addr",  addr_b,       32'hFFFF_FFF8);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("w2_pc",    pc_b,         32'hFFFF_FFF8);
        chk("w2_op",    32'(op_b),    32'h4);
        cyc(0, 0, 0);
        chk("w3_pc",    pc_b,         32'hFFFF_FFFC);
        cyc(0, 0, 0);
        chk("w4_pc",    pc_b,         32'h0000_0000);
        chk("w4_instr", instr_b,      32'h1000_0000);
        cyc(0, 0, 0);
        rst_b = 1'b1; #1;
        chk("mr_valid", 32'(valid_b), 32'd0);
        chk("mr_req",   32'(req_b),   32'd0);
        chk("mr_pc",    pc_b,         32'd0);
        cyc(0, 0, 0);
        rst_b = 1'b0; #1;
        chk("mr0_addr", addr_b,       32'hFFFF_FFF8);
        cyc(0, 0, 0);
        chk("mr1_valid", 32'(valid_b), 32'd0);
        cyc(0, 0, 0);
        chk("mr2_pc",   pc_b,         32'hFFFF_FFF8);

`ifdef FETCH_PERF_CNT_EN
        // 3 stalled-valid cycles followed by 10 pops
        cyc(0, 0, 0);
        rst_a = 1'b1; #1;
        cyc(0, 0, 0);
        rst_a = 1'b0; #1;
        chk("pf_rst_f", perf_f_a,     32'd0);
        chk("pf_rst_s", perf_s_a,     32'd0);
        cyc(0, 0, 0);
        repeat (3) cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("pf_fetched", perf_f_a,   32'd10);
        chk("pf_stall",   perf_s_a,   32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
